baud_rate_sequencer: RTL
========================

# baud_rate_sequencer

Steps a variable-rate UART through a fixed table of eight standard baud rates. On an up/down step request it computes the new clocks-per-bit period with a sequential divider. It commits the period only while the UART reports idle, so no character is ever split across two rates. It sits between the user step inputs (debounced buttons) and the UART TX/RX period inputs.

## Interface
- CLK_FREQ, 25000000, system clock frequency in Hz; 32-bit unsigned.
- RESET_INDEX, 5, table index loaded at reset (0..7).
- i_Clk  in  1  system clock; all state updates on the rising edge.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_Step_Up  in  1  one-cycle pulse requesting the next higher rate.
- i_Step_Down  in  1  one-cycle pulse requesting the next lower rate.
- i_Uart_Busy  in  1  high while the UART TX or RX is mid-character.
- o_Period  out  20  committed clocks per bit, fed to the UART.
- o_Index  out  3  table index of the committed rate.
- o_Period_Valid  out  1  one-cycle strobe when o_Period/o_Index change.
- o_Busy  out  1  high while a step is in progress; new steps are ignored.

## Operation
- Rate table by index: 0=110, 1=300, 2=1200, 3=2400, 4=4800, 5=9600, 6=19200, 7=115200.
- Period = floor(CLK_FREQ / rate), computed as an unsigned 32-bit by 17-bit restoring division, one quotient bit per cycle, MSB first.
- If the quotient exceeds 20'hFFFFF, o_Period saturates to 20'hFFFFF.
- Reset values:
  - o_Index = RESET_INDEX.
  - o_Period = CLK_FREQ / rate[RESET_INDEX], an elaboration-time constant with the same saturation rule.
  - o_Period_Valid = 0, o_Busy = 0, state IDLE.
- State machine:
  - IDLE: accept i_Step_Up if o_Index < 7, setting pending = o_Index+1. Accept i_Step_Down if o_Index > 0, setting pending = o_Index−1. In both cases clear the remainder, load the dividend and go to DIVIDE.
  - In IDLE, a step at a table end (up at 7, down at 0) is ignored; no wrap.
  - In IDLE, both step inputs high in the same cycle is ignored.
  - DIVIDE: 32 iterations tracked by a 5-bit counter, then go to WAIT_IDLE.
  - WAIT_IDLE: hold until i_Uart_Busy = 0. On that edge load o_Period = quotient (saturated) and o_Index = pending, pulse o_Period_Valid, and return to IDLE.
- Steps arriving while o_Busy = 1 are dropped, not queued.
- o_Period and o_Index change only on the commit edge and never hold a partial result.

## Timing
- Step pulse sampled on edge E0: o_Busy = 1 after E0.
- Divide iterations occur on E1..E32.
- Earliest commit is E33, i.e. step-to-new-period latency of 33 cycles.
- Each cycle i_Uart_Busy stays high after E32 adds one cycle of latency; wait time is unbounded.
- At the commit edge:
  - o_Busy falls to 0.
  - o_Period_Valid is high for exactly the following cycle.
  - o_Period and o_Index hold their new values from that edge on.
- A step presented in the same cycle that o_Period_Valid is high is accepted (state is IDLE).
- i_Uart_Busy is sampled only in WAIT_IDLE. During DIVIDE it has no effect.
- Reset asserted mid-step (DIVIDE or WAIT_IDLE): immediately abort, with no commit and no o_Period_Valid pulse. All outputs return to reset values while i_Rst_L is low.
- After i_Rst_L deasserts, the first step is accepted on the first rising edge.

## Test plan
- Reset with CLK_FREQ=25000000, RESET_INDEX=5 -> o_Period=2604, o_Index=5, o_Busy=0, o_Period_Valid=0.
- Step-up, then step-up again after each commit (i_Uart_Busy=0) -> commits 1302 (index 6) then 217 (index 7):
  - each commit 33 cycles after its step;
  - exactly one o_Period_Valid pulse per commit.
- At index 7, step-up -> no o_Busy and no o_Period_Valid; o_Period stays 217.
- Step-down seven times from index 7 -> periods 1302, 2604, 5208, 10416, 20833, 83333, 227272. A further step-down at index 0 is ignored.
- Step-up with i_Uart_Busy held high 100 cycles past E32 -> o_Period unchanged until i_Uart_Busy falls, committed on that edge. Extra steps pulsed during the wait are dropped.
- i_Rst_L pulsed low at cycle 10 of DIVIDE -> no o_Period_Valid; o_Period returns to 2604. Both step inputs high in one IDLE cycle -> ignored.

Source files
------------

// File: rtl/baud_rate_sequencer.sv
// Baud-rate sequencer: steps a UART through eight standard rates, computes the
// clocks-per-bit period with a serial restoring divider and commits it only
// while the UART is idle.
module baud_rate_sequencer #(
  parameter int unsigned CLK_FREQ    = 25000000,
  parameter int unsigned RESET_INDEX = 5
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Step_Up,
  input  logic        i_Step_Down,
  input  logic        i_Uart_Busy,
  output logic [19:0] o_Period,
  output logic [2:0]  o_Index,
  output logic        o_Period_Valid,
  output logic        o_Busy
);

  function automatic logic [16:0] rate_of(input logic [2:0] idx);
    case (idx)
      3'd0:    rate_of = 17'd110;
      3'd1:    rate_of = 17'd300;
      3'd2:    rate_of = 17'd1200;
      3'd3:    rate_of = 17'd2400;
      3'd4:    rate_of = 17'd4800;
      3'd5:    rate_of = 17'd9600;
      3'd6:    rate_of = 17'd19200;
      default: rate_of = 17'd115200;
    endcase
  endfunction

  localparam logic [2:0]  ResetIndex  = 3'(RESET_INDEX);
  localparam logic [31:0] ResetQuot   = 32'(CLK_FREQ) / {15'd0, rate_of(ResetIndex)};
  localparam logic [19:0] ResetPeriod = (ResetQuot > 32'hFFFFF) ? 20'hFFFFF : ResetQuot[19:0];

  typedef enum logic [1:0] {StIdle, StDivide, StWaitIdle} state_e;

  state_e      state_q, state_d;
  logic [2:0]  pending_q, pending_d;
  logic [16:0] divisor_q, divisor_d;
  logic [16:0] rem_q, rem_d;
  // Holds the dividend initially; quotient bits shift in at the LSB.
  logic [31:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] period_q, period_d;
  logic [2:0]  index_q, index_d;
  logic        valid_q, valid_d;

  logic [17:0] partial;
  logic        fits;
  logic        start;
  logic [2:0]  next_idx;
  logic [19:0] quot_sat;

  // Divider datapath and step decode.
  always_comb begin
    partial  = {rem_q, quot_q[31]};
    fits     = partial >= {1'b0, divisor_q};
    quot_sat = (quot_q[31:20] != 12'd0) ? 20'hFFFFF : quot_q[19:0];
    start    = 1'b0;
    next_idx = index_q;
    if (i_Step_Up && !i_Step_Down && index_q != 3'd7) begin
      start    = 1'b1;
      next_idx = index_q + 3'd1;
    end else if (i_Step_Down && !i_Step_Up && index_q != 3'd0) begin
      start    = 1'b1;
      next_idx = index_q - 3'd1;
    end
  end

  // Next-state logic: accept step, iterate divider, wait for idle UART, commit.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    index_d   = index_q;
    valid_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          pending_d = next_idx;
          divisor_d = rate_of(next_idx);
          rem_d     = 17'd0;
          quot_d    = 32'(CLK_FREQ);
          cnt_d     = 5'd0;
          state_d   = StDivide;
        end
      end
      StDivide: begin
        // Remainder stays below the divisor, so 17-bit wraparound is exact.
        rem_d  = fits ? (partial[16:0] - divisor_q) : partial[16:0];
        quot_d = {quot_q[30:0], fits};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StWaitIdle;
      end
      StWaitIdle: begin
        if (!i_Uart_Busy) begin
          period_d = quot_sat;
          index_d  = pending_q;
          valid_d  = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any step in flight.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      pending_q <= ResetIndex;
      divisor_q <= 17'd0;
      rem_q     <= 17'd0;
      quot_q    <= 32'd0;
      cnt_q     <= 5'd0;
      period_q  <= ResetPeriod;
      index_q   <= ResetIndex;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
    end
  end

  assign o_Period       = period_q;
  assign o_Index        = index_q;
  assign o_Period_Valid = valid_q;
  assign o_Busy         = (state_q != StIdle);

endmodule
